// File: rtl/key_frontend.sv
`default_nettype none
// ============================================================================
// Module      : key_frontend
// Description : Synchronizes and debounces 14 calculator keys into
//               one-cycle, priority-resolved key pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_frontend #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] push_n,
    input  logic       plus_n,
    input  logic       minus_n,
    input  logic       equal_n,
    input  logic       ce_n,
    output logic [9:0] push,
    output logic       plus,
    output logic       minus,
    output logic       equal,
    output logic       ce,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       multi_key,
    output logic       busy
);

    localparam int              c_nkeys    = 14;
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]      c_code_plus  = 4'd10;
    localparam logic [3:0]      c_code_minus = 4'd11;
    localparam logic [3:0]      c_code_equal = 4'd12;
    localparam logic [3:0]      c_code_ce    = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // Bit index equals the key code, so priority is simply the highest set bit.
    logic [c_nkeys-1:0] w_raw;
    logic [c_nkeys-1:0] r_sync1;
    logic [c_nkeys-1:0] r_keys;

    assign w_raw = ~{ce_n, equal_n, minus_n, plus_n, push_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_keys  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_keys  <= r_sync1;
        end
    end

    logic [3:0]  w_sel;
    logic        w_any;
    logic        w_multi;
    logic        w_held;
    logic [15:0] w_keys16;

    always_comb begin
        w_sel = 4'd0;
        for (int i = 0; i < c_nkeys; i++) begin
            if (r_keys[i]) begin
                w_sel = 4'(i);
            end
        end
    end

    assign w_any    = |r_keys;
    assign w_multi  = |(r_keys & (r_keys - 14'd1));
    assign w_keys16 = {2'b00, r_keys};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_key;

    assign w_held = w_keys16[r_key];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_key     <= 4'd0;
            push      <= '0;
            plus      <= 1'b0;
            minus     <= 1'b0;
            equal     <= 1'b0;
            ce        <= 1'b0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            busy      <= 1'b0;
        end else begin
            push      <= '0;
            plus      <= 1'b0;
            minus     <= 1'b0;
            equal     <= 1'b0;
            ce        <= 1'b0;
            key_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_key     <= w_sel;
                        multi_key <= w_multi;
                        r_cnt     <= '0;
                        r_state   <= S_DEBOUNCE;
                        busy      <= 1'b1;
                    end
                end

                S_DEBOUNCE: begin
                    if (!w_held) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == c_deb_last) begin
                        if (r_key < 4'd10) begin
                            push <= 10'd1 << r_key;
                        end
                        plus      <= (r_key == c_code_plus);
                        minus     <= (r_key == c_code_minus);
                        equal     <= (r_key == c_code_equal);
                        ce        <= (r_key == c_code_ce);
                        key_code  <= r_key;
                        key_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_PRESSED;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_PRESSED: begin
                    if (!w_any) begin
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    // Any key activity while releasing restarts the quiet period.
                    if (w_any) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_cnt     <= '0;
                        multi_key <= 1'b0;
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
